// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed seven-segment display path.
//   seg_t      : segment vector a..g, index 0 = a, active-low
//   SEG_BLANK  : all segments dark
//   AN_OFF     : all eight digit enables inactive (active-low anodes)
//   SEG_TABLE  : hex digit -> segment pattern (0-9, A, b, C, d, E, F)
//   hex_seg()  : table lookup helper
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t       SEG_BLANK = 7'b1111111;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Literals are written a..g left to right, which lands a in index 0.
  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic seg_t hex_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational hex digit to seven-segment decoder.
//   nibble : in  4  hex digit
//   seg    : out 7  segments a..g (seg[0] = a), active-low
// -----------------------------------------------------------------------------
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Scans a 4*DIGITS-bit hex value onto a multiplexed common-anode display.
// New data is staged and only committed at a frame boundary so a frame never
// mixes old and new digits. Optional leading-zero blanking and per-digit DPs.
//   CLK100MHZ  : in  1        system clock
//   CPU_RESETN : in  1        asynchronous active-low reset
//   load_i     : in  1        one-cycle strobe, stages data_i/dp_i
//   data_i     : in  4*DIGITS nibble k drives digit k (digit 0 rightmost)
//   dp_i       : in  DIGITS   decimal point per digit, 1 = lit
//   blank_lz_i : in  1        1 = blank leading-zero digits
//   pending_o  : out 1        staged data not yet committed
//   AN         : out DIGITS   digit enables, active-low
//   HEX0       : out [0:6]    segments a..g, active-low
//   DP         : out 1        decimal point, active-low
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV    = 100_000,  // clock cycles per digit slot, >= 2
  parameter int DIGITS = 8
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  blank_lz_i,
  output logic                  pending_o,
  output logic [DIGITS-1:0]     AN,
  output seg_t                  HEX0,
  output logic                  DP
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_BLANK = {DIGITS{AN_OFF[0]}};

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              tick;
  logic              frame_end;
  logic              commit;

  logic [DATA_W-1:0] staged_data;
  logic [DIGITS-1:0] staged_dp;
  logic [DATA_W-1:0] shown_data;
  logic [DIGITS-1:0] shown_dp;
  logic [DATA_W-1:0] shown_data_nxt;
  logic [DIGITS-1:0] shown_dp_nxt;

  logic [3:0]        nibble;
  logic              dp_bit;
  logic              lz_blank;
  seg_t              seg;

  // ---------------------------------------------------------------------------
  // Slot timing
  // ---------------------------------------------------------------------------
  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);
  assign idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt <= '0;
      idx <= IDX_LAST;  // first tick lands on digit 0 and is a frame boundary
    end else if (tick) begin
      cnt <= '0;
      idx <= idx_nxt;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Staging / commit
  // ---------------------------------------------------------------------------
  assign commit         = frame_end && pending_o;
  assign shown_data_nxt = commit ? staged_data : shown_data;
  assign shown_dp_nxt   = commit ? staged_dp   : shown_dp;

  // NOTE: the data registers are reset because the display must show a
  // defined value (all zeros) from the first scanned frame onward.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      staged_data <= '0;
      staged_dp   <= '0;
      shown_data  <= '0;
      shown_dp    <= '0;
      pending_o   <= 1'b0;
    end else begin
      if (commit) begin
        shown_data <= staged_data;
        shown_dp   <= staged_dp;
        pending_o  <= 1'b0;
      end
      // Placed after the commit so a load on the boundary cycle keeps
      // pending set; the commit above still takes the old staged value.
      if (load_i) begin
        staged_data <= data_i;
        staged_dp   <= dp_i;
        pending_o   <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select and leading-zero detection, evaluated for the slot that the
  // output registers are about to present (next idx, next shown value).
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nibble   = '0;
    dp_bit   = 1'b0;
    lz_blank = blank_lz_i && (idx_nxt != '0);
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_nxt == IDX_W'(k)) begin
        nibble = shown_data_nxt[4*k +: 4];
        dp_bit = shown_dp_nxt[k];
      end
      if ((IDX_W'(k) >= idx_nxt) && (shown_data_nxt[4*k +: 4] != 4'h0)) begin
        lz_blank = 1'b0;
      end
    end
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (seg)
  );

  // ---------------------------------------------------------------------------
  // Output registers: updated only on a tick, so they stay blank until the
  // first tick after reset and at most one anode is ever low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      AN   <= AN_BLANK;
      HEX0 <= SEG_BLANK;
      DP   <= 1'b1;
    end else if (tick) begin
      if (lz_blank) begin
        AN   <= AN_BLANK;
        HEX0 <= SEG_BLANK;
        DP   <= 1'b1;
      end else begin
        AN   <= ~(DIGITS'(1) << idx_nxt);
        HEX0 <= seg;
        DP   <= ~dp_bit;
      end
    end
  end

endmodule
